// File: rtl/ram32_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram32_arb_pkg                                                |
// | Description : Shared constants for the RAM32 bus arbiter: sequencer state  |
// |               encoding, owner encoding, default word-address width and a   |
// |               byte-lane helper.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ram32_arb_pkg;

  // RAM32 macro: 32 words, so 5 word-address bits.
  localparam int DEFAULT_AW = 5;

  // Sequencer states. Kept as plain sized constants so the encoding matches
  // existing netlists and waveform decoders.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // Owner encoding. It doubles as the bit index into the one-hot grant vector.
  typedef logic [1:0] owner_t;
  localparam owner_t OWN_IBUS = 2'd0;
  localparam owner_t OWN_DBUS = 2'd1;
  localparam owner_t OWN_HOST = 2'd2;

  // Write-enable mask for a single byte lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram32_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram32_bus_arbiter_if                                         |
// | Description : Requester-side buses of the RAM32 arbiter.                   |
// |   ibus : i_ibus_cyc, i_ibus_adr[31:0] -> o_ibus_rdt[31:0], o_ibus_ack      |
// |   dbus : i_dbus_cyc, i_dbus_we, i_dbus_adr[31:0], i_dbus_dat[31:0],        |
// |          i_dbus_sel[3:0]            -> o_dbus_rdt[31:0], o_dbus_ack        |
// |   host : i_host_req, i_host_we, i_host_adr[AW+1:0], i_host_dat[7:0]        |
// |                                     -> o_host_rdt[7:0], o_host_ack         |
// |   Modport master = requesters, modport slave = arbiter.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ram32_bus_arbiter_if
  import ram32_arb_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) ();

  logic          i_ibus_cyc;
  logic [31:0]   i_ibus_adr;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;

  logic          i_dbus_cyc;
  logic          i_dbus_we;
  logic [31:0]   i_dbus_adr;
  logic [31:0]   i_dbus_dat;
  logic [3:0]    i_dbus_sel;
  logic [31:0]   o_dbus_rdt;
  logic          o_dbus_ack;

  logic          i_host_req;
  logic          i_host_we;
  logic [AW+1:0] i_host_adr;
  logic [7:0]    i_host_dat;
  logic [7:0]    o_host_rdt;
  logic          o_host_ack;

  modport master (
    output i_ibus_cyc, i_ibus_adr,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_cyc, i_dbus_we, i_dbus_adr, i_dbus_dat, i_dbus_sel,
    input  o_dbus_rdt, o_dbus_ack,
    output i_host_req, i_host_we, i_host_adr, i_host_dat,
    input  o_host_rdt, o_host_ack
  );

  modport slave (
    input  i_ibus_cyc, i_ibus_adr,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_cyc, i_dbus_we, i_dbus_adr, i_dbus_dat, i_dbus_sel,
    output o_dbus_rdt, o_dbus_ack,
    input  i_host_req, i_host_we, i_host_adr, i_host_dat,
    output o_host_rdt, o_host_ack
  );

endinterface
`default_nettype wire

// File: rtl/ram32_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram32_arb_pick                                               |
// | Description : Combinational grant selection. Fixed priority host > dbus >  |
// |               ibus, except that a host which won the previous grant yields |
// |               to any pending CPU request.                                  |
// |   i_ibus_req, i_dbus_req, i_host_req : pending requests                    |
// |   i_host_last                        : host won the previous grant         |
// |   o_grant[2:0]                       : one-hot, indexed by owner encoding  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram32_arb_pick
  import ram32_arb_pkg::*;
(
  input  wire logic       i_ibus_req,
  input  wire logic       i_dbus_req,
  input  wire logic       i_host_req,
  input  wire logic       i_host_last,
  output logic [2:0]      o_grant
);

  logic w_cpu_req;
  logic w_host_win;

  assign w_cpu_req  = i_ibus_req | i_dbus_req;
  // One-shot demotion: after a host grant, the host only wins again if no
  // CPU request is waiting. This keeps a looping host loader from starving SERV.
  assign w_host_win = i_host_req & ~(i_host_last & w_cpu_req);

  always_comb begin
    o_grant = 3'b000;
    if (w_host_win) begin
      o_grant[OWN_HOST] = 1'b1;
    end else if (i_dbus_req) begin
      o_grant[OWN_DBUS] = 1'b1;
    end else if (i_ibus_req) begin
      o_grant[OWN_IBUS] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram32_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram32_bus_arbiter                                            |
// | Description : Shares one RAM32 macro between the SERV instruction bus, the |
// |               SERV data bus and the byte-wide host port. Every access runs |
// |               IDLE -> ACCESS -> RESP; host bytes are steered onto lanes.   |
// |   clk, rst_n       : clock, synchronous active-low reset                   |
// |   bus (slave)      : ibus / dbus / host requester buses                    |
// |   o_ram_en         : RAM EN0, high only in ACCESS                          |
// |   o_ram_a[AW-1:0]  : RAM A0                                                |
// |   o_ram_we[3:0]    : RAM WE0 byte enables                                  |
// |   o_ram_di[31:0]   : RAM Di0                                               |
// |   i_ram_do[31:0]   : RAM Do0, valid in RESP                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram32_bus_arbiter
  import ram32_arb_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ram32_bus_arbiter_if.slave bus,
  output logic               o_ram_en,
  output logic [AW-1:0]      o_ram_a,
  output logic [3:0]         o_ram_we,
  output logic [31:0]        o_ram_di,
  input  wire logic [31:0]   i_ram_do
);

  state_t        r_state;
  owner_t        r_owner;
  logic [AW-1:0] r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_mask;
  logic [1:0]    r_idx;
  logic          r_host_last;

  logic [2:0]    w_grant;
  logic          w_access;
  logic          w_resp;
  logic          w_ibus_ack;
  logic          w_dbus_ack;
  logic          w_host_ack;

  // Only [AW+1:2] of the CPU byte addresses select a word; the rest alias.
  logic          w_unused_adr_bits;
  assign w_unused_adr_bits = ^{bus.i_ibus_adr[31:AW+2], bus.i_ibus_adr[1:0],
                               bus.i_dbus_adr[31:AW+2], bus.i_dbus_adr[1:0]};

  ram32_arb_pick u_pick (
    .i_ibus_req  (bus.i_ibus_cyc),
    .i_dbus_req  (bus.i_dbus_cyc),
    .i_host_req  (bus.i_host_req),
    .i_host_last (r_host_last),
    .o_grant     (w_grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IBUS;
      r_adr       <= '0;
      r_dat       <= 32'd0;
      r_mask      <= 4'b0000;
      r_idx       <= 2'd0;
      r_host_last <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant != 3'b000) begin
            r_state     <= ST_ACCESS;
            r_host_last <= w_grant[OWN_HOST];
            if (w_grant[OWN_HOST]) begin
              r_owner <= OWN_HOST;
              r_adr   <= bus.i_host_adr[AW+1:2];
              r_idx   <= bus.i_host_adr[1:0];
              r_dat   <= 32'(bus.i_host_dat) << {bus.i_host_adr[1:0], 3'b000};
              r_mask  <= bus.i_host_we ? lane_mask(bus.i_host_adr[1:0]) : 4'b0000;
            end else if (w_grant[OWN_DBUS]) begin
              r_owner <= OWN_DBUS;
              r_adr   <= bus.i_dbus_adr[AW+1:2];
              r_idx   <= 2'd0;
              r_dat   <= bus.i_dbus_dat;
              // A write with sel=0 still runs the full sequence and acks.
              r_mask  <= bus.i_dbus_we ? bus.i_dbus_sel : 4'b0000;
            end else begin
              r_owner <= OWN_IBUS;
              r_adr   <= bus.i_ibus_adr[AW+1:2];
              r_idx   <= 2'd0;
              r_dat   <= 32'd0;
              r_mask  <= 4'b0000;
            end
          end
        end
        ST_ACCESS: r_state <= ST_RESP;
        ST_RESP:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Qualify with rst_n so that a reset landing in ACCESS cannot commit a write
  // and a reset landing in RESP cannot leak an ack.
  assign w_access = rst_n && (r_state == ST_ACCESS);
  assign w_resp   = rst_n && (r_state == ST_RESP);

  assign o_ram_en = w_access;
  assign o_ram_we = w_access ? r_mask : 4'b0000;
  assign o_ram_a  = w_access ? r_adr  : '0;
  assign o_ram_di = w_access ? r_dat  : 32'd0;

  assign w_ibus_ack = w_resp && (r_owner == OWN_IBUS);
  assign w_dbus_ack = w_resp && (r_owner == OWN_DBUS);
  assign w_host_ack = w_resp && (r_owner == OWN_HOST);

  assign bus.o_ibus_ack = w_ibus_ack;
  assign bus.o_dbus_ack = w_dbus_ack;
  assign bus.o_host_ack = w_host_ack;

  // Read data is a straight gated path from the macro output.
  assign bus.o_ibus_rdt = w_ibus_ack ? i_ram_do : 32'd0;
  assign bus.o_dbus_rdt = w_dbus_ack ? i_ram_do : 32'd0;
  assign bus.o_host_rdt = w_host_ack ? i_ram_do[{r_idx, 3'b000} +: 8] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ram32_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram32_bus_arbiter                                         |
// | Description : Self-checking bench for ram32_bus_arbiter. A behavioural     |
// |               RAM32 macro sits on the RAM ports; expected results come     |
// |               from a byte-addressed memory image and a priority rule.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ram32_bus_arbiter;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          o_ram_en;
  logic [AW-1:0] o_ram_a;
  logic [3:0]    o_ram_we;
  logic [31:0]   o_ram_di;
  logic [31:0]   i_ram_do;

  always #5 clk = ~clk;

  ram32_bus_arbiter_if #(.AW(AW)) bus ();

  ram32_bus_arbiter #(.AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .o_ram_en (o_ram_en),
    .o_ram_a  (o_ram_a),
    .o_ram_we (o_ram_we),
    .o_ram_di (o_ram_di),
    .i_ram_do (i_ram_do)
  );

  // Behavioural RAM32 macro: byte write enables, registered read.
  logic [31:0] ram_mem [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (o_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (o_ram_we[b]) ram_mem[o_ram_a][8*b +: 8] <= o_ram_di[8*b +: 8];
      i_ram_do <= ram_mem[o_ram_a];
    end
  end

  // Reference: memory as 128 bytes, byte address = word*4 + lane.
  logic [7:0]  ref_b [128] = '{default: 8'h0};
  logic        host_last_m;

  int          checks;
  int          errors;

  // Per-requester transaction parameters, index 0 ibus, 1 dbus, 2 host.
  logic [2:0]  t_we;
  logic [31:0] t_adr [3];
  logic [31:0] t_dat [3];
  logic [3:0]  t_sel [3];

  // Observations captured by run_round for directed follow-up checks.
  logic [31:0] acc_a, acc_we, acc_di, last_rdt;
  int          order [8];
  int          n_order;
  int          alt_exp [3] = '{2, 0, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int word);
    return {ref_b[word*4+3], ref_b[word*4+2], ref_b[word*4+1], ref_b[word*4]};
  endfunction

  // Priority rule: host first unless it won last time and a CPU bus waits.
  function automatic int pick(input logic [2:0] p, input logic hl);
    if (p[2] && !(hl && (p[0] || p[1]))) return 2;
    if (p[1]) return 1;
    if (p[0]) return 0;
    return -1;
  endfunction

  function automatic int ack_owner();
    if (bus.o_host_ack) return 2;
    if (bus.o_dbus_ack) return 1;
    if (bus.o_ibus_ack) return 0;
    return 3;
  endfunction

  task automatic set_tx(input int o, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
    t_we[o] = we; t_adr[o] = adr; t_dat[o] = dat; t_sel[o] = sel;
  endtask

  task automatic drive(input logic [2:0] p);
    bus.i_ibus_cyc = p[0];
    bus.i_ibus_adr = t_adr[0];
    bus.i_dbus_cyc = p[1];
    bus.i_dbus_we  = t_we[1];
    bus.i_dbus_adr = t_adr[1];
    bus.i_dbus_dat = t_dat[1];
    bus.i_dbus_sel = t_sel[1];
    bus.i_host_req = p[2];
    bus.i_host_we  = t_we[2];
    bus.i_host_adr = t_adr[2][AW+1:0];
    bus.i_host_dat = t_dat[2][7:0];
  endtask

  // Check the RESP cycle for owner w and fold its write into the reference.
  task automatic check_resp(input int w);
    int word;
    word = int'(t_adr[w][AW+1:2]);
    check("resp_owner", 32'(ack_owner()), 32'(w));
    check("resp_en", 32'(o_ram_en), 32'd0);
    if (w != 0) check("resp_ibus_rdt_zero", bus.o_ibus_rdt, 32'd0);
    if (w != 1) check("resp_dbus_rdt_zero", bus.o_dbus_rdt, 32'd0);
    if (w != 2) check("resp_host_rdt_zero", 32'(bus.o_host_rdt), 32'd0);
    if (w == 0) begin
      last_rdt = bus.o_ibus_rdt;
      check("ibus_rdt", bus.o_ibus_rdt, ref_word(word));
    end else if (w == 1) begin
      last_rdt = bus.o_dbus_rdt;
      if (!t_we[1]) check("dbus_rdt", bus.o_dbus_rdt, ref_word(word));
      else for (int b = 0; b < 4; b++)
        if (t_sel[1][b]) ref_b[word*4+b] = t_dat[1][8*b +: 8];
    end else begin
      last_rdt = 32'(bus.o_host_rdt);
      if (!t_we[2]) check("host_rdt", 32'(bus.o_host_rdt), 32'(ref_b[int'(t_adr[2][AW+1:0])]));
      else ref_b[int'(t_adr[2][AW+1:0])] = t_dat[2][7:0];
    end
    host_last_m = (w == 2);
  endtask

  // Serve every requester in p; each holds its request until its ack and
  // drops it for the following IDLE. Starts and ends at an IDLE negedge.
  task automatic run_round(input logic [2:0] p_in);
    logic [2:0]  p;
    logic [3:0]  exp_we;
    logic [31:0] exp_di;
    int          w, idx;
    p = p_in;
    for (int r = 0; r < 3; r++) begin
      if (p != 3'b000) begin
        drive(p);
        w = pick(p, host_last_m);
        @(negedge clk);                                   // ACCESS
        idx    = int'(t_adr[w][1:0]);
        exp_we = 4'b0000;
        exp_di = t_dat[w];
        if (w == 2) begin
          exp_di = 32'd0;
          exp_di[idx*8 +: 8] = t_dat[2][7:0];
          if (t_we[2]) exp_we[idx] = 1'b1;
        end else if (w == 1 && t_we[1]) begin
          exp_we = t_sel[1];
        end
        acc_a = 32'(o_ram_a); acc_we = 32'(o_ram_we); acc_di = o_ram_di;
        check("access_en", 32'(o_ram_en), 32'd1);
        check("access_a", acc_a, 32'(t_adr[w][AW+1:2]));
        check("access_we", acc_we, 32'(exp_we));
        if (exp_we != 4'b0000) check("access_di", acc_di, exp_di);
        check("access_noack", 32'({bus.o_ibus_ack, bus.o_dbus_ack, bus.o_host_ack}), 32'd0);
        @(negedge clk);                                   // RESP
        check_resp(w);
        order[n_order % 8] = ack_owner();
        n_order++;
        p[w] = 1'b0;
        drive(p);
        @(negedge clk);                                   // IDLE
        check("idle_noack", 32'({bus.o_ibus_ack, bus.o_dbus_ack, bus.o_host_ack}), 32'd0);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; host_last_m = 1'b0; n_order = 0; last_rdt = 32'd0;

    // Reset held with every requester active.
    set_tx(0, 1'b0, 32'h0000_0004, 32'd0, 4'h0);
    set_tx(1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF);
    set_tx(2, 1'b1, 32'h0000_0001, 32'h0000_00FF, 4'h0);
    rst_n = 1'b0;
    drive(3'b111);
    repeat (2) begin
      @(negedge clk);
      check("rst_acks", 32'({bus.o_ibus_ack, bus.o_dbus_ack, bus.o_host_ack}), 32'd0);
      check("rst_en", 32'(o_ram_en), 32'd0);
      check("rst_we", 32'(o_ram_we), 32'd0);
      check("rst_rdt", bus.o_ibus_rdt | bus.o_dbus_rdt | 32'(bus.o_host_rdt), 32'd0);
    end
    drive(3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Host write 0xA5 to byte address 0x07, then read it back.
    set_tx(2, 1'b1, 32'h07, 32'hA5, 4'h0);
    run_round(3'b100);
    check("host_wr_a", acc_a, 32'd1);
    check("host_wr_we", acc_we, 32'b1000);
    check("host_wr_di", acc_di, 32'hA500_0000);
    set_tx(2, 1'b0, 32'h07, 32'h00, 4'h0);
    run_round(3'b100);
    check("host_rd_byte", last_rdt, 32'h0000_00A5);

    // Partial dbus write into a zeroed word, then an ibus fetch of it.
    set_tx(1, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'b0011);
    run_round(3'b010);
    check("dbus_wr_we", acc_we, 32'b0011);
    check("dbus_wr_a", acc_a, 32'd2);
    set_tx(0, 1'b0, 32'h08, 32'd0, 4'h0);
    run_round(3'b001);
    check("ibus_rd_word", last_rdt, 32'h0000_BEEF);

    // All three at once: host, dbus, ibus at T+2, T+5, T+8.
    set_tx(0, 1'b0, 32'h10, 32'd0, 4'h0);
    set_tx(1, 1'b1, 32'h14, 32'hCAFE_F00D, 4'hF);
    set_tx(2, 1'b0, 32'h07, 32'd0, 4'h0);
    n_order = 0;
    run_round(3'b111);
    check("order_first", 32'(order[0]), 32'd2);
    check("order_second", 32'(order[1]), 32'd1);
    check("order_third", 32'(order[2]), 32'd0);

    // Host re-requests after each ack while ibus stays high: host, ibus, host.
    set_tx(2, 1'b0, 32'h07, 32'd0, 4'h0);
    set_tx(0, 1'b0, 32'h08, 32'd0, 4'h0);
    drive(3'b101);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);                                     // ACCESS
      @(negedge clk);                                     // RESP
      check("alt_owner", 32'(ack_owner()), 32'(alt_exp[k]));
      if (alt_exp[k] == 2) check("alt_host_rdt", 32'(bus.o_host_rdt), 32'hA5);
      else                 check("alt_ibus_rdt", bus.o_ibus_rdt, 32'h0000_BEEF);
      host_last_m = (alt_exp[k] == 2);
      @(negedge clk);                                     // IDLE
    end
    drive(3'b000);
    @(negedge clk);

    // Reset pulled during ACCESS of a dbus write: no write, no ack.
    set_tx(1, 1'b1, 32'h0C, 32'h1234_5678, 4'hF);
    drive(3'b010);
    @(negedge clk);                                       // ACCESS
    rst_n = 1'b0;
    drive(3'b000);
    #1;
    check("rst_access_we", 32'(o_ram_we), 32'd0);
    check("rst_access_en", 32'(o_ram_en), 32'd0);
    @(negedge clk);
    check("rst_access_noack", 32'({bus.o_ibus_ack, bus.o_dbus_ack, bus.o_host_ack}), 32'd0);
    rst_n = 1'b1;
    host_last_m = 1'b0;
    @(negedge clk);
    check("rst_after_noack", 32'({bus.o_ibus_ack, bus.o_dbus_ack, bus.o_host_ack}), 32'd0);
    set_tx(1, 1'b0, 32'h0C, 32'd0, 4'h0);
    run_round(3'b010);
    check("rst_word_kept", last_rdt, 32'h0000_0000);

    // Randomised mixes of requesters, with aliased upper address bits.
    repeat (40) begin
      set_tx(0, 1'b0, $urandom, $urandom, 4'h0);
      set_tx(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      set_tx(2, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'h0);
      run_round(3'($urandom_range(1, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
